branch_resolve_unit: RTL and testbench

ID-stage branch control for the 5-stage MIPS pipeline, wrapped around the branch comparator. Upstream, it drives the forwarding selects that feed the comparator's RD1/RD2 muxes and stalls IF/ID while operands are unavailable. Downstream, it consumes the comparator flags (EQUAL, NotEQUAL, IsBiggerThanZero, IsLessThanZero, IsZero) to produce PC source, branch target select and IF/ID flush. It also keeps saturating branch statistics.

---
 rtl/mips_branch_pkg.sv | 40 ++++
 rtl/branch_hazard_detect.sv | 58 +++++
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_branch_pkg.sv
// rtl/mips_branch_pkg.sv - branch type codes, forwarding selects, FSM states and taken evaluation
package mips_branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BGTZ = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Reserved codes (6, 7) fall through to not-taken.
    function automatic logic br_taken(
        input logic [2:0] br_type,
        input logic       equal,
        input logic       not_equal,
        input logic       gt_zero,
        input logic       lt_zero,
        input logic       is_zero
    );
        case (br_type)
            BR_BEQ:  br_taken = equal;
            BR_BNE:  br_taken = not_equal;
            BR_BGTZ: br_taken = gt_zero;
            BR_BLEZ: br_taken = lt_zero | is_zero;
            BR_BLTZ: br_taken = lt_zero;
            BR_BGEZ: br_taken = ~lt_zero;
            default: br_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// rtl/branch_hazard_detect.sv - stall length and comparator forwarding selects for a branch in ID
module branch_hazard_detect
    import mips_branch_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       hazard_cycles,
    output logic [1:0]       fwd_rd1_sel,
    output logic [1:0]       fwd_rd2_sel
);

    logic ex_dep1, ex_dep2, mem_dep1, mem_dep2, wb_dep1, wb_dep2;
    logic [1:0] cyc1, cyc2;

    // A stage is a producer only if it writes a non-zero register matching the source.
    always_comb begin
        ex_dep1  = ex_regwrite  && (ex_rd  != '0) && (ex_rd  == id_rs);
        ex_dep2  = ex_regwrite  && (ex_rd  != '0) && (ex_rd  == id_rt);
        mem_dep1 = mem_regwrite && (mem_rd != '0) && (mem_rd == id_rs);
        mem_dep2 = mem_regwrite && (mem_rd != '0) && (mem_rd == id_rt);
        wb_dep1  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == id_rs);
        wb_dep2  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == id_rt);
    end

    // Per-source wait, then the longer of the two governs the stall.
    always_comb begin
        cyc1 = 2'd0;
        cyc2 = 2'd0;
        if (ex_dep1 && ex_memread)         cyc1 = 2'd2;
        else if (ex_dep1)                  cyc1 = 2'd1;
        else if (mem_dep1 && mem_memread)  cyc1 = 2'd1;
        if (ex_dep2 && ex_memread)         cyc2 = 2'd2;
        else if (ex_dep2)                  cyc2 = 2'd1;
        else if (mem_dep2 && mem_memread)  cyc2 = 2'd1;
        hazard_cycles = (cyc1 > cyc2) ? cyc1 : cyc2;
    end

    // Youngest ready value wins: an ALU result in MEM beats anything in WB.
    always_comb begin
        fwd_rd1_sel = FWD_RF;
        fwd_rd2_sel = FWD_RF;
        if (mem_dep1 && !mem_memread) fwd_rd1_sel = FWD_EXMEM;
        else if (wb_dep1)             fwd_rd1_sel = FWD_MEMWB;
        if (mem_dep2 && !mem_memread) fwd_rd2_sel = FWD_EXMEM;
        else if (wb_dep2)             fwd_rd2_sel = FWD_MEMWB;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch stall FSM, resolution and saturating statistics
module branch_resolve_unit
    import mips_branch_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic [2:0]       id_br_type,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             equal,
    input  logic             not_equal,
    input  logic             gt_zero,
    input  logic             lt_zero,
    input  logic             is_zero,
    output logic [1:0]       fwd_rd1_sel,
    output logic [1:0]       fwd_rd2_sel,
    output logic             stall,
    output logic             pc_src,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [1:0] hz_cycles;
    logic [1:0] n_cycles;
    logic       is_br;
    logic       taken;
    logic       resolve;

    branch_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_regwrite   (ex_regwrite),
        .ex_memread    (ex_memread),
        .ex_rd         (ex_rd),
        .mem_regwrite  (mem_regwrite),
        .mem_memread   (mem_memread),
        .mem_rd        (mem_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .hazard_cycles (hz_cycles),
        .fwd_rd1_sel   (fwd_rd1_sel),
        .fwd_rd2_sel   (fwd_rd2_sel)
    );

    // Hazards only matter for a valid branch sitting in ID.
    always_comb begin
        is_br    = id_valid && id_branch;
        n_cycles = is_br ? hz_cycles : 2'd0;
        taken    = br_taken(id_br_type, equal, not_equal, gt_zero, lt_zero, is_zero);
    end

    // State and remaining-stall register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: a 2-cycle hazard parks in STALL for one extra cycle; a 1-cycle hazard
    // stays in IDLE and is re-evaluated once the bubble has moved the producer along.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (n_cycles != 2'd0) begin
                    cnt_n   = n_cycles - 2'd1;
                    state_n = (n_cycles > 2'd1) ? ST_STALL : ST_IDLE;
                end
            end
            ST_STALL: begin
                if (cnt <= 2'd1) begin
                    cnt_n   = 2'd0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 2'd1;
                end
            end
            default: begin
                cnt_n   = 2'd0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs: stall while waiting, otherwise resolve the branch this cycle.
    always_comb begin
        stall      = 1'b0;
        pc_src     = 1'b0;
        ifid_flush = 1'b0;
        resolve    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (n_cycles != 2'd0) begin
                    stall = 1'b1;
                end else if (is_br) begin
                    resolve    = 1'b1;
                    pc_src     = taken;
                    ifid_flush = taken;
                end
            end
            default: stall = 1'b1;
        endcase
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (resolve && (branch_cnt != '1))          branch_cnt <= branch_cnt + 1'b1;
            if (resolve && taken && (taken_cnt != '1))  taken_cnt  <= taken_cnt + 1'b1;
            if (stall && (stall_cnt != '1))             stall_cnt  <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed vector table and multi-cycle sequences for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_branch;
    logic [2:0]  id_br_type;
    logic [4:0]  id_rs, id_rt;
    logic        ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_regwrite, mem_memread;
    logic [4:0]  mem_rd;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic        equal, not_equal, gt_zero, lt_zero, is_zero;
    logic [1:0]  fwd_rd1_sel, fwd_rd2_sel;
    logic        stall, pc_src, ifid_flush;
    logic [15:0] branch_cnt, taken_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_branch    (id_branch),
        .id_br_type   (id_br_type),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_memread  (mem_memread),
        .mem_rd       (mem_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_rd        (wb_rd),
        .equal        (equal),
        .not_equal    (not_equal),
        .gt_zero      (gt_zero),
        .lt_zero      (lt_zero),
        .is_zero      (is_zero),
        .fwd_rd1_sel  (fwd_rd1_sel),
        .fwd_rd2_sel  (fwd_rd2_sel),
        .stall        (stall),
        .pc_src       (pc_src),
        .ifid_flush   (ifid_flush),
        .branch_cnt   (branch_cnt),
        .taken_cnt    (taken_cnt),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        logic       v, b;
        logic [2:0] t;
        logic [4:0] rs, rt;
        logic       exw, exm;
        logic [4:0] exrd;
        logic       memw, memm;
        logic [4:0] memrd;
        logic       wbw;
        logic [4:0] wbrd;
        logic [4:0] fl;      // {equal, not_equal, gt_zero, lt_zero, is_zero}
        logic       e_st, e_pc, e_fl;
        logic [1:0] e_f1, e_f2;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    function automatic vec_t mk(int v, int b, int t, int rs, int rt,
                                int exw, int exm, int exrd,
                                int memw, int memm, int memrd,
                                int wbw, int wbrd, int fl,
                                int st, int pc, int flu, int f1, int f2);
        vec_t m;
        m.v = 1'(v);      m.b = 1'(b);      m.t = 3'(t);
        m.rs = 5'(rs);    m.rt = 5'(rt);
        m.exw = 1'(exw);  m.exm = 1'(exm);  m.exrd = 5'(exrd);
        m.memw = 1'(memw); m.memm = 1'(memm); m.memrd = 5'(memrd);
        m.wbw = 1'(wbw);  m.wbrd = 5'(wbrd);
        m.fl = 5'(fl);
        m.e_st = 1'(st);  m.e_pc = 1'(pc);  m.e_fl = 1'(flu);
        m.e_f1 = 2'(f1);  m.e_f2 = 2'(f2);
        return m;
    endfunction

    task automatic apply(input vec_t x);
        id_valid = x.v; id_branch = x.b; id_br_type = x.t;
        id_rs = x.rs; id_rt = x.rt;
        ex_regwrite = x.exw; ex_memread = x.exm; ex_rd = x.exrd;
        mem_regwrite = x.memw; mem_memread = x.memm; mem_rd = x.memrd;
        wb_regwrite = x.wbw; wb_rd = x.wbrd;
        {equal, not_equal, gt_zero, lt_zero, is_zero} = x.fl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic st, input logic pc, input logic fl);
        chk({tag, "_stall"}, 32'(stall), 32'(st));
        chk({tag, "_pc_src"}, 32'(pc_src), 32'(pc));
        chk({tag, "_flush"}, 32'(ifid_flush), 32'(fl));
    endtask

    task automatic chk_cnts(input string tag, input int b, input int t, input int s);
        chk({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(b));
        chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(t));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(s));
    endtask

    initial begin
        //          v b t rs rt exw exm exrd memw memm memrd wbw wbrd fl       st pc fl f1 f2
        tv[0]  = mk(1,1,0, 8, 8, 0,0,0,   0,0,0,  0,0,  5'b10000, 0,1,1, 0,0); // BEQ taken
        tv[1]  = mk(1,1,0, 8, 8, 0,0,0,   0,0,0,  0,0,  5'b01000, 0,0,0, 0,0); // BEQ not taken
        tv[2]  = mk(1,1,1, 1, 2, 0,0,0,   0,0,0,  0,0,  5'b01000, 0,1,1, 0,0); // BNE taken
        tv[3]  = mk(1,1,2, 1, 0, 0,0,0,   0,0,0,  0,0,  5'b00100, 0,1,1, 0,0); // BGTZ taken
        tv[4]  = mk(1,1,3, 1, 0, 0,0,0,   0,0,0,  0,0,  5'b00001, 0,1,1, 0,0); // BLEZ via zero
        tv[5]  = mk(1,1,3, 1, 0, 0,0,0,   0,0,0,  0,0,  5'b00010, 0,1,1, 0,0); // BLEZ via negative
        tv[6]  = mk(1,1,4, 1, 0, 0,0,0,   0,0,0,  0,0,  5'b00101, 0,0,0, 0,0); // BLTZ not taken
        tv[7]  = mk(1,1,5, 1, 0, 0,0,0,   0,0,0,  0,0,  5'b00001, 0,1,1, 0,0); // BGEZ on zero
        tv[8]  = mk(1,1,5, 1, 0, 0,0,0,   0,0,0,  0,0,  5'b00010, 0,0,0, 0,0); // BGEZ negative
        tv[9]  = mk(1,1,7, 1, 2, 0,0,0,   0,0,0,  0,0,  5'b11111, 0,0,0, 0,0); // reserved 7
        tv[10] = mk(1,1,6, 1, 2, 0,0,0,   0,0,0,  0,0,  5'b11101, 0,0,0, 0,0); // reserved 6
        tv[11] = mk(1,1,0, 3, 4, 0,0,0,   1,0,3,  1,4,  5'b10000, 0,1,1, 1,2); // MEM ALU rs, WB rt
        tv[12] = mk(1,1,0, 0, 0, 1,1,0,   1,0,0,  1,0,  5'b10000, 0,1,1, 0,0); // rd=0 ignored
        tv[13] = mk(1,1,0, 5, 6, 0,0,0,   1,0,5,  1,5,  5'b00000, 0,0,0, 1,0); // MEM beats WB
        tv[14] = mk(1,1,0, 9, 2, 1,0,9,   0,0,0,  0,0,  5'b10000, 1,0,0, 0,0); // ALU in EX
        tv[15] = mk(1,1,1, 2, 7, 0,0,0,   1,1,7,  0,0,  5'b01000, 1,0,0, 0,0); // load in MEM on rt
        tv[16] = mk(1,0,0, 9, 9, 1,1,9,   0,0,0,  0,0,  5'b10000, 0,0,0, 0,0); // non-branch
        tv[17] = mk(0,1,0, 9, 9, 0,0,0,   0,0,0,  0,0,  5'b10000, 0,0,0, 0,0); // invalid ID
        tv[18] = mk(1,1,0,12,13, 0,0,0,   0,0,0,  0,12, 5'b10000, 0,1,1, 0,0); // WB without regwrite
        tv[19] = mk(1,1,0,11, 1, 0,0,0,   1,1,11, 1,11, 5'b10000, 1,0,0, 2,0); // MEM load + WB fwd

        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #2;
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_fwd1", 32'(fwd_rd1_sel), 32'd0);
        chk("reset_fwd2", 32'(fwd_rd2_sel), 32'd0);
        chk_cnts("reset", 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            apply(tv[i]);
            #2;
            chk_outs($sformatf("vec%0d", i), tv[i].e_st, tv[i].e_pc, tv[i].e_fl);
            chk($sformatf("vec%0d_fwd1", i), 32'(fwd_rd1_sel), 32'(tv[i].e_f1));
            chk($sformatf("vec%0d_fwd2", i), 32'(fwd_rd2_sel), 32'(tv[i].e_f2));
            step();
        end

        // Fresh counters for the sequences.
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk_cnts("seq_start", 0, 0, 0);

        // Taken BEQ then reserved type: both count as branches, only the first as taken.
        apply(tv[0]);
        step();
        chk_cnts("beq", 1, 1, 0);
        apply(tv[9]);
        step();
        chk_cnts("reserved", 2, 1, 0);

        // Load in EX feeding BNE: two stall cycles, resolution in the third.
        apply(mk(1,1,1, 9,2, 1,1,9, 0,0,0, 0,0, 5'b01000, 0,0,0,0,0));
        #2;
        chk_outs("ld_c1", 1'b1, 1'b0, 1'b0);
        step();
        apply(mk(1,1,1, 9,2, 0,0,0, 1,1,9, 0,0, 5'b01000, 0,0,0,0,0));
        #2;
        chk_outs("ld_c2", 1'b1, 1'b0, 1'b0);
        step();
        apply(mk(1,1,1, 9,2, 0,0,0, 0,0,0, 1,9, 5'b01000, 0,0,0,0,0));
        #2;
        chk_outs("ld_c3", 1'b0, 1'b1, 1'b1);
        chk("ld_c3_fwd1", 32'(fwd_rd1_sel), 32'd2);
        step();
        chk_cnts("ld_done", 3, 2, 2);

        // Reset while parked in STALL.
        apply(mk(1,1,1, 9,2, 1,1,9, 0,0,0, 0,0, 5'b01000, 0,0,0,0,0));
        step();
        rst = 1'b1;
        #2;
        chk("rst_mid_in_stall", 32'(stall), 32'd1);
        step();
        rst = 1'b0;
        apply(mk(1,1,0, 8,8, 0,0,0, 0,0,0, 0,0, 5'b01000, 0,0,0,0,0));
        #2;
        chk_outs("rst_mid_after", 1'b0, 1'b0, 1'b0);
        chk_cnts("rst_mid_after", 0, 0, 0);

        // Saturation: a persistent 1-cycle hazard stalls every cycle.
        apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        apply(mk(1,1,0, 9,2, 1,0,9, 0,0,0, 0,0, 5'b10000, 0,0,0,0,0));
        repeat (65534) step();
        chk("sat_fffe", 32'(stall_cnt), 32'h0000_fffe);
        step();
        chk("sat_ffff", 32'(stall_cnt), 32'h0000_ffff);
        repeat (5) step();
        chk("sat_hold", 32'(stall_cnt), 32'h0000_ffff);
        chk("sat_branch_cnt", 32'(branch_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
